// File: rtl/c16_mem_pkg.sv
// Shared types and constants for the C16 SRAM arbiter: FSM states, request
// sources, request kinds and the pending-entry payload.
package c16_mem_pkg;

    localparam int unsigned PADDR_W = 18;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CADDR_W = 16;

    localparam logic [PADDR_W-1:0] RAM_BASE_DEF = 18'h00000;
    localparam logic [PADDR_W-1:0] ROM_BASE_DEF = 18'h10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_LATCH
    } state_t;

    typedef enum logic {
        SRC_C16,
        SRC_DL
    } src_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_RAM,
        REQ_ROM
    } req_kind_t;

    typedef struct packed {
        logic [PADDR_W-1:0] addr;
        logic               write;
        logic [DATA_W-1:0]  data;
    } mem_req_t;

endpackage

// File: rtl/c16_addr_map.sv
// Turns C16 strobe edges into a request kind, 18-bit physical address and
// direction. A ROM edge always shadows a simultaneous CAS edge.
module c16_addr_map
    import c16_mem_pkg::*;
#(
    parameter logic [PADDR_W-1:0] RAM_BASE = RAM_BASE_DEF,
    parameter logic [PADDR_W-1:0] ROM_BASE = ROM_BASE_DEF
) (
    input  logic               cas_n,
    input  logic               cas_q,
    input  logic               cs0_n,
    input  logic               cs0_q,
    input  logic               cs1_n,
    input  logic               cs1_q,
    input  logic               rw,
    input  logic [3:0]         rom_sel,
    input  logic [CADDR_W-1:0] c16_addr,
    output req_kind_t          kind_c,
    output logic [PADDR_W-1:0] paddr_c,
    output logic               write_c
);

    logic       cas_fall;
    logic       cs0_fall;
    logic       cs1_fall;
    logic       kernal_side;
    logic [1:0] bank;

    assign cas_fall    = cas_q & ~cas_n;
    assign cs0_fall    = cs0_q & ~cs0_n;
    assign cs1_fall    = cs1_q & ~cs1_n;
    assign kernal_side = cs1_fall & ~cs0_fall;
    assign bank        = kernal_side ? rom_sel[3:2] : rom_sel[1:0];

    // ROM writes are swallowed; they also discard a coincident CAS edge
    always_comb begin
        kind_c  = REQ_NONE;
        paddr_c = '0;
        write_c = 1'b0;
        if (cs0_fall || cs1_fall) begin
            if (rw) begin
                kind_c  = REQ_ROM;
                paddr_c = ROM_BASE + PADDR_W'({bank, kernal_side, c16_addr[13:0]});
            end
        end else if (cas_fall) begin
            kind_c  = REQ_RAM;
            paddr_c = RAM_BASE + PADDR_W'(c16_addr);
            write_c = ~rw;
        end
    end

endmodule

// File: rtl/c16_mem_arbiter.sv
// Single-port SRAM sequencer shared by C16 RAM/ROM cycles and the ROM download
// port; C16 requests always win over the download buffer.
module c16_mem_arbiter
    import c16_mem_pkg::*;
#(
    parameter logic [PADDR_W-1:0] RAM_BASE = RAM_BASE_DEF,
    parameter logic [PADDR_W-1:0] ROM_BASE = ROM_BASE_DEF
) (
    input  logic               CLK28,
    input  logic               RESET_N,
    input  logic [CADDR_W-1:0] C16_ADDR,
    input  logic [DATA_W-1:0]  C16_DOUT,
    input  logic               RW,
    input  logic               CAS,
    input  logic               CS0,
    input  logic               CS1,
    input  logic [3:0]         ROM_SEL,
    output logic [DATA_W-1:0]  C16_DIN,
    input  logic               DL_WR,
    input  logic [PADDR_W-1:0] DL_ADDR,
    input  logic [DATA_W-1:0]  DL_DATA,
    output logic               DL_BUSY,
    output logic               DL_OVERRUN,
    output logic [PADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0]  MEM_DQ_O,
    input  logic [DATA_W-1:0]  MEM_DQ_I,
    output logic               MEM_CE_N,
    output logic               MEM_OE_N,
    output logic               MEM_WE_N
);

    logic               cas_q, cs0_q, cs1_q;
    req_kind_t          req_kind_c;
    logic [PADDR_W-1:0] req_addr_c;
    logic               req_write_c;

    state_t             state_q, state_d;
    src_t               src_q, src_d;
    logic               write_q, write_d;
    mem_req_t           c16_pend_q, c16_pend_d;
    logic               c16_valid_q, c16_valid_d;
    mem_req_t           dl_buf_q, dl_buf_d;
    logic               dl_valid_q, dl_valid_d;
    logic               dl_busy_d, dl_overrun_d;
    logic [PADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0]  mem_dq_d, c16_din_d;
    logic               ce_n_d, oe_n_d, we_n_d;

    c16_addr_map #(
        .RAM_BASE (RAM_BASE),
        .ROM_BASE (ROM_BASE)
    ) u_addr_map (
        .cas_n    (CAS),
        .cas_q    (cas_q),
        .cs0_n    (CS0),
        .cs0_q    (cs0_q),
        .cs1_n    (CS1),
        .cs1_q    (cs1_q),
        .rw       (RW),
        .rom_sel  (ROM_SEL),
        .c16_addr (C16_ADDR),
        .kind_c   (req_kind_c),
        .paddr_c  (req_addr_c),
        .write_c  (req_write_c)
    );

    // Next-state and next-output logic; strobe values describe the state being entered
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        write_d      = write_q;
        c16_pend_d   = c16_pend_q;
        c16_valid_d  = c16_valid_q;
        dl_buf_d     = dl_buf_q;
        dl_valid_d   = dl_valid_q;
        dl_busy_d    = DL_BUSY;
        dl_overrun_d = DL_OVERRUN;
        mem_addr_d   = MEM_ADDR;
        mem_dq_d     = MEM_DQ_O;
        c16_din_d    = C16_DIN;
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (c16_valid_q) begin
                    mem_addr_d  = c16_pend_q.addr;
                    mem_dq_d    = c16_pend_q.data;
                    write_d     = c16_pend_q.write;
                    src_d       = SRC_C16;
                    c16_valid_d = 1'b0;
                    ce_n_d      = 1'b0;
                    state_d     = ST_SETUP;
                end else if (dl_valid_q) begin
                    mem_addr_d = dl_buf_q.addr;
                    mem_dq_d   = dl_buf_q.data;
                    write_d    = dl_buf_q.write;
                    src_d      = SRC_DL;
                    dl_valid_d = 1'b0;
                    ce_n_d     = 1'b0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ce_n_d  = 1'b0;
                oe_n_d  = write_q;
                we_n_d  = ~write_q;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (!write_q) begin
                    c16_din_d = MEM_DQ_I;
                end
                if (src_q == SRC_DL) begin
                    dl_busy_d = 1'b0;
                end
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh C16 edge overwrites the pending entry, even one granted this cycle
        if (req_kind_c != REQ_NONE) begin
            c16_valid_d = 1'b1;
            c16_pend_d  = '{addr: req_addr_c, write: req_write_c, data: C16_DOUT};
        end

        if (DL_WR) begin
            if (DL_BUSY) begin
                dl_overrun_d = 1'b1;
            end else begin
                dl_buf_d   = '{addr: DL_ADDR, write: 1'b1, data: DL_DATA};
                dl_valid_d = 1'b1;
                dl_busy_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK28 or negedge RESET_N) begin
        if (!RESET_N) begin
            cas_q       <= 1'b1;
            cs0_q       <= 1'b1;
            cs1_q       <= 1'b1;
            state_q     <= ST_IDLE;
            src_q       <= SRC_C16;
            write_q     <= 1'b0;
            c16_pend_q  <= '0;
            c16_valid_q <= 1'b0;
            dl_buf_q    <= '0;
            dl_valid_q  <= 1'b0;
            DL_BUSY     <= 1'b0;
            DL_OVERRUN  <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_DQ_O    <= '0;
            C16_DIN     <= 8'hFF;
            MEM_CE_N    <= 1'b1;
            MEM_OE_N    <= 1'b1;
            MEM_WE_N    <= 1'b1;
        end else begin
            cas_q       <= CAS;
            cs0_q       <= CS0;
            cs1_q       <= CS1;
            state_q     <= state_d;
            src_q       <= src_d;
            write_q     <= write_d;
            c16_pend_q  <= c16_pend_d;
            c16_valid_q <= c16_valid_d;
            dl_buf_q    <= dl_buf_d;
            dl_valid_q  <= dl_valid_d;
            DL_BUSY     <= dl_busy_d;
            DL_OVERRUN  <= dl_overrun_d;
            MEM_ADDR    <= mem_addr_d;
            MEM_DQ_O    <= mem_dq_d;
            C16_DIN     <= c16_din_d;
            MEM_CE_N    <= ce_n_d;
            MEM_OE_N    <= oe_n_d;
            MEM_WE_N    <= we_n_d;
        end
    end

endmodule

// File: tb/tb_c16_mem_arbiter.sv
// Directed and randomized checks of c16_mem_arbiter against a byte-array
// memory image and an access log taken from the SRAM pins.
module tb_c16_mem_arbiter;

    localparam int unsigned MEM_SIZE = 262144;

    typedef struct packed {
        logic [17:0] addr;
        logic        we;
        logic [7:0]  data;
    } acc_t;

    logic        CLK28 = 1'b0;
    logic        RESET_N;
    logic [15:0] C16_ADDR;
    logic [7:0]  C16_DOUT;
    logic        RW, CAS, CS0, CS1;
    logic [3:0]  ROM_SEL;
    logic [7:0]  C16_DIN;
    logic        DL_WR;
    logic [17:0] DL_ADDR;
    logic [7:0]  DL_DATA;
    logic        DL_BUSY, DL_OVERRUN;
    logic [17:0] MEM_ADDR;
    logic [7:0]  MEM_DQ_O, MEM_DQ_I;
    logic        MEM_CE_N, MEM_OE_N, MEM_WE_N;

    logic [7:0]  sram    [MEM_SIZE];
    logic [7:0]  ref_mem [MEM_SIZE];
    acc_t        log_q   [$];
    logic [17:0] touched [$];

    int vectors     = 0;
    int miscompares = 0;

    always #10 CLK28 = ~CLK28;

    c16_mem_arbiter dut (
        .CLK28      (CLK28),
        .RESET_N    (RESET_N),
        .C16_ADDR   (C16_ADDR),
        .C16_DOUT   (C16_DOUT),
        .RW         (RW),
        .CAS        (CAS),
        .CS0        (CS0),
        .CS1        (CS1),
        .ROM_SEL    (ROM_SEL),
        .C16_DIN    (C16_DIN),
        .DL_WR      (DL_WR),
        .DL_ADDR    (DL_ADDR),
        .DL_DATA    (DL_DATA),
        .DL_BUSY    (DL_BUSY),
        .DL_OVERRUN (DL_OVERRUN),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DQ_O   (MEM_DQ_O),
        .MEM_DQ_I   (MEM_DQ_I),
        .MEM_CE_N   (MEM_CE_N),
        .MEM_OE_N   (MEM_OE_N),
        .MEM_WE_N   (MEM_WE_N)
    );

    // SRAM model: combinational read while selected, write and log at each strobed edge
    assign MEM_DQ_I = (!MEM_CE_N && !MEM_OE_N) ? sram[MEM_ADDR] : 8'h00;

    always @(posedge CLK28) begin
        if (RESET_N && !MEM_CE_N && !MEM_WE_N) begin
            sram[MEM_ADDR] = MEM_DQ_O;
            log_q.push_back('{MEM_ADDR, 1'b1, MEM_DQ_O});
        end else if (RESET_N && !MEM_CE_N && !MEM_OE_N) begin
            log_q.push_back('{MEM_ADDR, 1'b0, MEM_DQ_I});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK28);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ROM image layout: 32 KB per bank, Kernal half in the upper 16 KB of each bank
    function automatic logic [17:0] rom_phys(input logic [3:0] sel, input logic cs1,
                                             input logic [15:0] a);
        int unsigned bank;
        bank = cs1 ? 32'(sel[3:2]) : 32'(sel[1:0]);
        return 18'(32'h10000 + bank * 32'h8000 + (cs1 ? 32'h4000 : 32'h0) + 32'(a) % 32'h4000);
    endfunction

    initial begin
        int          base, nexp, op, dlm, n;
        logic [15:0] a;
        logic [7:0]  d, dld, exp_din;
        logic [3:0]  sel;
        logic        side;
        logic [17:0] phys, dla;

        for (int i = 0; i < int'(MEM_SIZE); i++) begin
            sram[i]    = 8'($urandom);
            ref_mem[i] = sram[i];
        end

        RESET_N = 1'b0; CAS = 1'b1; CS0 = 1'b1; CS1 = 1'b1; RW = 1'b1;
        C16_ADDR = '0; C16_DOUT = '0; ROM_SEL = '0;
        DL_WR = 1'b0; DL_ADDR = '0; DL_DATA = '0;
        tick(3);
        chk("rst_din",  32'(C16_DIN),  32'h0FF);
        chk("rst_ce",   32'(MEM_CE_N), 32'h1);
        chk("rst_oe",   32'(MEM_OE_N), 32'h1);
        chk("rst_we",   32'(MEM_WE_N), 32'h1);
        chk("rst_addr", 32'(MEM_ADDR), 32'h0);
        chk("rst_dq",   32'(MEM_DQ_O), 32'h0);
        chk("rst_busy", 32'(DL_BUSY),  32'h0);
        chk("rst_ovr",  32'(DL_OVERRUN), 32'h0);
        RESET_N = 1'b1;
        tick(3);
        chk("idle_no_access", 32'(log_q.size()), 32'h0);

        // RAM write then read back with exact latency
        C16_ADDR = 16'h1234; C16_DOUT = 8'hA5; RW = 1'b0; CAS = 1'b0;
        tick(4);
        chk("wr_count", 32'(log_q.size()), 32'h1);
        chk("wr_addr",  32'(log_q[0].addr), 32'h01234);
        chk("wr_we",    32'(log_q[0].we),   32'h1);
        chk("wr_data",  32'(log_q[0].data), 32'hA5);
        chk("wr_hold_we",   32'(MEM_WE_N), 32'h1);
        chk("wr_hold_addr", 32'(MEM_ADDR), 32'h01234);
        chk("wr_hold_dq",   32'(MEM_DQ_O), 32'hA5);
        ref_mem[18'h01234] = 8'hA5;
        tick(10); CAS = 1'b1; tick(2);
        RW = 1'b1; CAS = 1'b0;
        tick(3);
        chk("rd_early", 32'(C16_DIN), 32'h0FF);
        tick(1);
        chk("rd_data", 32'(C16_DIN), 32'hA5);
        tick(10); CAS = 1'b1; tick(2);

        // ROM bank mapping for both halves
        ROM_SEL = 4'b1001; C16_ADDR = 16'hF000; CS1 = 1'b0; base = log_q.size();
        tick(14);
        chk("rom1_addr", 32'(log_q[base].addr), 32'h27000);
        chk("rom1_din",  32'(C16_DIN), 32'(ref_mem[18'h27000]));
        CS1 = 1'b1; tick(2);
        C16_ADDR = 16'h8000; CS0 = 1'b0; base = log_q.size();
        tick(14);
        chk("rom0_addr", 32'(log_q[base].addr), 32'h18000);
        chk("rom0_din",  32'(C16_DIN), 32'(ref_mem[18'h18000]));
        CS0 = 1'b1; tick(2);

        // C16 beats a download strobed in the same cycle
        base = log_q.size();
        C16_ADDR = 16'h0100; C16_DOUT = 8'h11; RW = 1'b0; CAS = 1'b0;
        DL_ADDR = 18'h20000; DL_DATA = 8'h22; DL_WR = 1'b1;
        tick(1); DL_WR = 1'b0;
        tick(6);
        chk("prio_busy_hi", 32'(DL_BUSY), 32'h1);
        tick(1);
        chk("prio_busy_lo", 32'(DL_BUSY), 32'h0);
        tick(6); CAS = 1'b1; RW = 1'b1; tick(2);
        chk("prio_count", 32'(log_q.size() - base), 32'h2);
        chk("prio_first", 32'(log_q[base].addr), 32'h00100);
        chk("prio_second", 32'(log_q[base+1].addr), 32'h20000);
        chk("prio_dl_data", 32'(log_q[base+1].data), 32'h22);
        ref_mem[18'h00100] = 8'h11; ref_mem[18'h20000] = 8'h22;

        // Second strobe while busy is dropped and latches the sticky overrun flag
        base = log_q.size();
        DL_ADDR = 18'h21000; DL_DATA = 8'h33; DL_WR = 1'b1;
        tick(1); DL_WR = 1'b0;
        tick(1);
        DL_ADDR = 18'h21001; DL_DATA = 8'h44; DL_WR = 1'b1;
        tick(1); DL_WR = 1'b0;
        chk("ovr_set", 32'(DL_OVERRUN), 32'h1);
        tick(10);
        chk("ovr_sticky", 32'(DL_OVERRUN), 32'h1);
        chk("ovr_count", 32'(log_q.size() - base), 32'h1);
        chk("ovr_addr", 32'(log_q[base].addr), 32'h21000);
        chk("ovr_dropped", 32'(sram[18'h21001]), 32'(ref_mem[18'h21001]));
        ref_mem[18'h21000] = 8'h33;

        // CS0 and CAS together: one cycle, at the ROM address
        base = log_q.size(); ROM_SEL = 4'b0110; C16_ADDR = 16'h4567;
        phys = rom_phys(ROM_SEL, 1'b0, C16_ADDR);
        CS0 = 1'b0; CAS = 1'b0;
        tick(14);
        chk("sim_count", 32'(log_q.size() - base), 32'h1);
        chk("sim_addr",  32'(log_q[base].addr), 32'(phys));
        chk("sim_din",   32'(C16_DIN), 32'(ref_mem[phys]));
        CS0 = 1'b1; CAS = 1'b1; tick(2);

        // Reset asserted mid-write aborts without a clock edge
        base = log_q.size();
        C16_ADDR = 16'h0042; C16_DOUT = 8'h5A; RW = 1'b0; CAS = 1'b0;
        n = 0;
        while (MEM_WE_N !== 1'b0 && n < 10) begin
            tick(1);
            n++;
        end
        chk("rst_we_reached", 32'(MEM_WE_N), 32'h0);
        #4 RESET_N = 1'b0;
        #1;
        chk("rstm_we",   32'(MEM_WE_N), 32'h1);
        chk("rstm_ce",   32'(MEM_CE_N), 32'h1);
        chk("rstm_addr", 32'(MEM_ADDR), 32'h0);
        chk("rstm_dq",   32'(MEM_DQ_O), 32'h0);
        chk("rstm_din",  32'(C16_DIN),  32'h0FF);
        chk("rstm_ovr",  32'(DL_OVERRUN), 32'h0);
        CAS = 1'b1; RW = 1'b1;
        tick(2); RESET_N = 1'b1;
        tick(10);
        chk("rstm_no_access", 32'(log_q.size() - base), 32'h0);
        chk("rstm_mem", 32'(sram[18'h00042]), 32'(ref_mem[18'h00042]));
        exp_din = 8'hFF;

        // Randomized C16 operations with optional contending downloads
        for (int it = 0; it < 40; it++) begin
            op   = int'($urandom_range(0, 3));
            dlm  = int'($urandom_range(0, 2));
            a    = 16'($urandom);
            d    = 8'($urandom);
            dld  = 8'($urandom);
            sel  = 4'($urandom);
            side = 1'($urandom_range(0, 1));
            phys = (op < 2) ? 18'(a) : rom_phys(sel, side, a);
            dla  = 18'(32'h10000 + $urandom_range(0, 32'h1FFFF));
            if (dla == phys) dla = dla ^ 18'h1;
            base = log_q.size();

            if (dlm == 2) begin
                DL_ADDR = dla; DL_DATA = dld; DL_WR = 1'b1;
                tick(1); DL_WR = 1'b0;
            end
            C16_ADDR = a; C16_DOUT = d; ROM_SEL = sel;
            RW = (op == 0 || op == 2);
            if (op < 2) CAS = 1'b0;
            else if (side) CS1 = 1'b0;
            else CS0 = 1'b0;
            if (dlm == 1) begin
                DL_ADDR = dla; DL_DATA = dld; DL_WR = 1'b1;
            end
            tick(1); DL_WR = 1'b0;
            tick(6);
            if (op == 0 || op == 2) exp_din = ref_mem[phys];
            chk("rnd_din", 32'(C16_DIN), 32'(exp_din));
            if (op == 1) begin
                ref_mem[phys] = d;
                touched.push_back(phys);
            end
            if (dlm != 0) begin
                ref_mem[dla] = dld;
                touched.push_back(dla);
            end
            tick(7);
            CAS = 1'b1; CS0 = 1'b1; CS1 = 1'b1; RW = 1'b1;
            tick(2);

            nexp = 0;
            if (op != 3) nexp++;
            if (dlm != 0) nexp++;
            chk("rnd_count", 32'(log_q.size() - base), 32'(nexp));
            if (dlm == 1 && op != 3) chk("rnd_prio", 32'(log_q[base].addr), 32'(phys));
            if (dlm == 2) chk("rnd_dl_first", 32'(log_q[base].addr), 32'(dla));
            chk("rnd_busy", 32'(DL_BUSY), 32'h0);
        end
        chk("rnd_ovr", 32'(DL_OVERRUN), 32'h0);
        foreach (touched[i]) chk("rnd_mem", 32'(sram[touched[i]]), 32'(ref_mem[touched[i]]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
